// File: rtl/inverse_rotate_pkg.sv
// rtl/inverse_rotate_pkg.sv - shared widths, rho offset table and FSM encodings for the lane rotate steps
package inverse_rotate_pkg;

  localparam int LANE_W    = 64;
  localparam int NUM_LANES = 25;
  localparam int NUM_CELLS = NUM_LANES * LANE_W;
  localparam int CNT_W     = 5;
  localparam int ROT_W     = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Single source of the rho offsets so the forward and inverse steps cannot diverge.
  function automatic logic [ROT_W-1:0] rho_offset(input logic [CNT_W-1:0] lane);
    logic [ROT_W-1:0] r;
    r = '0;
    case (lane)
      5'd0:  r = 6'd0;
      5'd1:  r = 6'd1;
      5'd2:  r = 6'd62;
      5'd3:  r = 6'd28;
      5'd4:  r = 6'd27;
      5'd5:  r = 6'd36;
      5'd6:  r = 6'd44;
      5'd7:  r = 6'd6;
      5'd8:  r = 6'd55;
      5'd9:  r = 6'd20;
      5'd10: r = 6'd3;
      5'd11: r = 6'd10;
      5'd12: r = 6'd43;
      5'd13: r = 6'd25;
      5'd14: r = 6'd39;
      5'd15: r = 6'd41;
      5'd16: r = 6'd45;
      5'd17: r = 6'd15;
      5'd18: r = 6'd21;
      5'd19: r = 6'd8;
      5'd20: r = 6'd18;
      5'd21: r = 6'd2;
      5'd22: r = 6'd61;
      5'd23: r = 6'd56;
      5'd24: r = 6'd14;
      default: r = 6'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inverse_rotate_lane_rotr.sv
// rtl/inverse_rotate_lane_rotr.sv - combinational lane rotate-right by a 6-bit amount
module inverse_rotate_lane_rotr
  import inverse_rotate_pkg::*;
(
  input  logic [LANE_W-1:0] lane,
  input  logic [ROT_W-1:0]  amount,
  output logic [LANE_W-1:0] rotated
);

  logic [2*LANE_W-1:0] doubled;

  // Selecting a window of the doubled lane gives the rotation with no shift by LANE_W at amount 0.
  assign doubled = {lane, lane};
  assign rotated = doubled[amount +: LANE_W];

endmodule

// File: rtl/inverse_rotate.sv
// rtl/inverse_rotate.sv - inverse rho step: rotates each lane right by its offset, one lane per clock
module inverse_rotate
  import inverse_rotate_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_CELLS-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_CELLS-1:0] data_out
);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     count_q;
  logic [NUM_CELLS-1:0] cells_q;
  logic [CNT_W-1:0]     lane_idx;
  logic [LANE_W-1:0]    lane_cur;
  logic [LANE_W-1:0]    lane_rot;
  logic                 last_lane;

  // Out-of-range counter values fall back to lane 0 so they never address past the state.
  assign lane_idx  = (count_q < CNT_W'(NUM_LANES)) ? count_q : '0;
  assign lane_cur  = cells_q[lane_idx*LANE_W +: LANE_W];
  assign last_lane = (count_q == CNT_W'(NUM_LANES - 1));

  inverse_rotate_lane_rotr u_rotr (
    .lane    (lane_cur),
    .amount  (rho_offset(lane_idx)),
    .rotated (lane_rot)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_lane) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      cells_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cells_q <= data_in;
            count_q <= '0;
          end
        end
        ST_RUN: begin
          cells_q[lane_idx*LANE_W +: LANE_W] <= lane_rot;
          count_q <= last_lane ? '0 : count_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign data_out = cells_q;

endmodule
